// File: rtl/pitch_pkg.sv
// pitch_pkg: constants and types shared by the pitch renderer files.
//   - visible-area geometry, which must agree with the VGA timing generator
//   - game geometry defaults (bird, pipe, ground)
//   - flash timing and the flash-state enum
//   - RGB332 colour constants, laid out as {red[7:5], green[4:2], blue[1:0]}
package pitch_pkg;

   // Visible area of the 640x480 mode, expressed in VGA counter units
   localparam int unsigned H_START = 32'd144;
   localparam int unsigned V_START = 32'd35;
   localparam int unsigned H_VIS   = 32'd640;
   localparam int unsigned V_VIS   = 32'd480;

   // Game geometry in visible coordinates
   localparam int unsigned BIRD_X    = 32'd100;
   localparam int unsigned BIRD_SIZE = 32'd16;
   localparam int unsigned PIPE_W    = 32'd48;
   localparam int unsigned GROUND_Y  = 32'd448;

   // Collision flash timing; the counter width holds FLASH_FRAMES-1 and
   // must be wider than FLASH_PERIOD_LOG2
   localparam int unsigned FLASH_FRAMES      = 32'd60;
   localparam int unsigned FLASH_PERIOD_LOG2 = 32'd3;
   localparam int unsigned CNT_W             = 32'd6;

   // RGB332 colours
   localparam logic [7:0] COL_BLACK  = 8'h00;
   localparam logic [7:0] COL_BIRD   = 8'hFC;
   localparam logic [7:0] COL_PIPE   = 8'h14;
   localparam logic [7:0] COL_GROUND = 8'h88;
   localparam logic [7:0] COL_SKY    = 8'h57;
   localparam logic [7:0] COL_FLASH  = 8'hE0;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLASH = 1'b1
   } flash_state_t;

endpackage

// File: rtl/pitch_region_test.sv
// pitch_region_test: combinational stage-1 geometry for one pixel.
//   Ports:
//     hc, vc          - VGA counters of the pixel being evaluated
//     bird_y          - bird top edge (visible y, frame-latched copy)
//     pipe_x          - pipe left edge (visible x, frame-latched copy)
//     pipe_y_top      - bottom of the upper pipe, exclusive
//     pipe_y_bot      - top of the lower pipe, inclusive
//     vis             - pixel lies in the visible area
//     in_bird/in_pipe/in_ground - region membership flags
//   All arithmetic is done in 11 bits so right/bottom edges near the 10-bit
//   limit clip instead of wrapping. Region flags are only meaningful when
//   vis is set; the caller gates them.
module pitch_region_test
   import pitch_pkg::*;
#(
   parameter int unsigned P_H_START   = H_START,
   parameter int unsigned P_V_START   = V_START,
   parameter int unsigned P_H_VIS     = H_VIS,
   parameter int unsigned P_V_VIS     = V_VIS,
   parameter int unsigned P_BIRD_X    = BIRD_X,
   parameter int unsigned P_BIRD_SIZE = BIRD_SIZE,
   parameter int unsigned P_PIPE_W    = PIPE_W,
   parameter int unsigned P_GROUND_Y  = GROUND_Y
) (
   input  logic [9:0] hc,
   input  logic [9:0] vc,
   input  logic [9:0] bird_y,
   input  logic [9:0] pipe_x,
   input  logic [9:0] pipe_y_top,
   input  logic [9:0] pipe_y_bot,
   output logic       vis,
   output logic       in_bird,
   output logic       in_pipe,
   output logic       in_ground
);

   localparam logic [10:0] H_LO   = 11'(P_H_START);
   localparam logic [10:0] H_HI   = 11'(P_H_START + P_H_VIS);
   localparam logic [10:0] V_LO   = 11'(P_V_START);
   localparam logic [10:0] V_HI   = 11'(P_V_START + P_V_VIS);
   localparam logic [10:0] BX_LO  = 11'(P_BIRD_X);
   localparam logic [10:0] BX_HI  = 11'(P_BIRD_X + P_BIRD_SIZE);
   localparam logic [10:0] BSIZE  = 11'(P_BIRD_SIZE);
   localparam logic [10:0] PW     = 11'(P_PIPE_W);
   localparam logic [10:0] GY     = 11'(P_GROUND_Y);

   logic [10:0] hc_s;
   logic [10:0] vc_s;
   logic [10:0] x_s;
   logic [10:0] y_s;
   logic [10:0] bird_top_s;
   logic [10:0] bird_end_s;
   logic [10:0] pipe_left_s;
   logic [10:0] pipe_end_s;
   logic        pipe_col_s;
   logic        pipe_gap_out_s;

   assign hc_s = {1'b0, hc};
   assign vc_s = {1'b0, vc};

   // Off-screen pixels produce wrapped x/y here, which is harmless because vis gates them
   assign x_s = hc_s - H_LO;
   assign y_s = vc_s - V_LO;

   assign vis = (hc_s >= H_LO) && (hc_s < H_HI) && (vc_s >= V_LO) && (vc_s < V_HI);

   assign bird_top_s = {1'b0, bird_y};
   assign bird_end_s = bird_top_s + BSIZE;
   assign in_bird    = (x_s >= BX_LO) && (x_s < BX_HI) &&
                       (y_s >= bird_top_s) && (y_s < bird_end_s);

   // A pipe running past the right edge is clipped by vis, never wrapped
   assign pipe_left_s    = {1'b0, pipe_x};
   assign pipe_end_s     = pipe_left_s + PW;
   assign pipe_col_s     = (x_s >= pipe_left_s) && (x_s < pipe_end_s);
   assign pipe_gap_out_s = (y_s < {1'b0, pipe_y_top}) || (y_s >= {1'b0, pipe_y_bot});
   assign in_pipe        = pipe_col_s && pipe_gap_out_s;

   assign in_ground = (y_s >= GY);

endmodule

// File: rtl/pitch_renderer.sv
// pitch_renderer: RGB332 pixel generator for the pitch game.
//   Ports:
//     clk        - pixel clock shared with the VGA generator
//     reset      - synchronous, active-low
//     hc, vc     - VGA counters
//     bird_y, pipe_x, pipe_y_top, pipe_y_bot - live game state, sampled once per frame
//     collided   - collision indication, may be a single-cycle pulse
//     out_red, out_green, out_blue - colour, two clocks after hc/vc
//     frame_tick - one-cycle pulse following the frame latch point
//   Game state is copied to shadow registers on the first blanking line so a
//   frame is always drawn from a single consistent snapshot.
module pitch_renderer
   import pitch_pkg::*;
#(
   parameter int unsigned P_H_START           = H_START,
   parameter int unsigned P_V_START           = V_START,
   parameter int unsigned P_H_VIS             = H_VIS,
   parameter int unsigned P_V_VIS             = V_VIS,
   parameter int unsigned P_BIRD_X            = BIRD_X,
   parameter int unsigned P_BIRD_SIZE         = BIRD_SIZE,
   parameter int unsigned P_PIPE_W            = PIPE_W,
   parameter int unsigned P_GROUND_Y          = GROUND_Y,
   parameter int unsigned P_FLASH_FRAMES      = FLASH_FRAMES,
   parameter int unsigned P_FLASH_PERIOD_LOG2 = FLASH_PERIOD_LOG2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hc,
   input  logic [9:0] vc,
   input  logic [9:0] bird_y,
   input  logic [9:0] pipe_x,
   input  logic [9:0] pipe_y_top,
   input  logic [9:0] pipe_y_bot,
   input  logic       collided,
   output logic [2:0] out_red,
   output logic [2:0] out_green,
   output logic [1:0] out_blue,
   output logic       frame_tick
);

   localparam logic [9:0]       LATCH_VC   = 10'(P_V_START + P_V_VIS);
   localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(P_FLASH_FRAMES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);

   // Frame snapshot
   logic [9:0]       bird_y_r;
   logic [9:0]       pipe_x_r;
   logic [9:0]       pipe_y_top_r;
   logic [9:0]       pipe_y_bot_r;

   logic             latch_s;
   logic             coll_sticky_r;
   logic             coll_hit_s;

   flash_state_t     state_r;
   flash_state_t     state_nx_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;

   logic             vis_s;
   logic             in_bird_s;
   logic             in_pipe_s;
   logic             in_ground_s;
   logic             vis_r;
   logic             in_bird_r;
   logic             in_pipe_r;
   logic             in_ground_r;

   logic [7:0]       colour_s;
   logic [7:0]       colour_r;
   logic             frame_tick_r;

   assign latch_s = (hc == 10'd0) && (vc == LATCH_VC);

   // A collision arriving on the latch cycle itself belongs to this latch
   assign coll_hit_s = coll_sticky_r | collided;

   // Shadow copy of game state, taken only at the latch point
   always_ff @(posedge clk) begin
      if (!reset) begin
         bird_y_r     <= 10'd0;
         pipe_x_r     <= 10'd0;
         pipe_y_top_r <= 10'd0;
         pipe_y_bot_r <= 10'd0;
      end else if (latch_s) begin
         bird_y_r     <= bird_y;
         pipe_x_r     <= pipe_x;
         pipe_y_top_r <= pipe_y_top;
         pipe_y_bot_r <= pipe_y_bot;
      end else begin
         bird_y_r     <= bird_y_r;
         pipe_x_r     <= pipe_x_r;
         pipe_y_top_r <= pipe_y_top_r;
         pipe_y_bot_r <= pipe_y_bot_r;
      end
   end

   // Sticky collision: remembers short pulses until the latch consumes them
   always_ff @(posedge clk) begin
      if (!reset) begin
         coll_sticky_r <= 1'b0;
      end else if (latch_s) begin
         coll_sticky_r <= 1'b0;
      end else if (collided) begin
         coll_sticky_r <= 1'b1;
      end else begin
         coll_sticky_r <= coll_sticky_r;
      end
   end

   // Flash FSM state and frame counter registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_RUN;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
      end
   end

   // Flash FSM next state: only moves at the latch; a fresh collision reloads the counter
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         ST_RUN: begin
            if (latch_s && coll_hit_s) begin
               state_nx_s = ST_FLASH;
               cnt_nx_s   = FLASH_LOAD;
            end else begin
               state_nx_s = ST_RUN;
               cnt_nx_s   = cnt_r;
            end
         end
         ST_FLASH: begin
            if (latch_s) begin
               if (coll_hit_s) begin
                  state_nx_s = ST_FLASH;
                  cnt_nx_s   = FLASH_LOAD;
               end else if (cnt_r == CNT_ZERO) begin
                  state_nx_s = ST_RUN;
                  cnt_nx_s   = CNT_ZERO;
               end else begin
                  state_nx_s = ST_FLASH;
                  cnt_nx_s   = cnt_r - CNT_ONE;
               end
            end else begin
               state_nx_s = ST_FLASH;
               cnt_nx_s   = cnt_r;
            end
         end
         default: begin
            state_nx_s = ST_RUN;
            cnt_nx_s   = CNT_ZERO;
         end
      endcase
   end

   pitch_region_test #(
      .P_H_START   (P_H_START),
      .P_V_START   (P_V_START),
      .P_H_VIS     (P_H_VIS),
      .P_V_VIS     (P_V_VIS),
      .P_BIRD_X    (P_BIRD_X),
      .P_BIRD_SIZE (P_BIRD_SIZE),
      .P_PIPE_W    (P_PIPE_W),
      .P_GROUND_Y  (P_GROUND_Y)
   ) u_region (
      .hc         (hc),
      .vc         (vc),
      .bird_y     (bird_y_r),
      .pipe_x     (pipe_x_r),
      .pipe_y_top (pipe_y_top_r),
      .pipe_y_bot (pipe_y_bot_r),
      .vis        (vis_s),
      .in_bird    (in_bird_s),
      .in_pipe    (in_pipe_s),
      .in_ground  (in_ground_s)
   );

   // Stage 1: register visibility and region flags
   always_ff @(posedge clk) begin
      if (!reset) begin
         vis_r       <= 1'b0;
         in_bird_r   <= 1'b0;
         in_pipe_r   <= 1'b0;
         in_ground_r <= 1'b0;
      end else begin
         vis_r       <= vis_s;
         in_bird_r   <= in_bird_s;
         in_pipe_r   <= in_pipe_s;
         in_ground_r <= in_ground_s;
      end
   end

   // Stage 2 colour priority: blank, bird, pipe, ground, then background
   always_comb begin
      colour_s = COL_BLACK;
      if (!vis_r) begin
         colour_s = COL_BLACK;
      end else if (in_bird_r) begin
         colour_s = COL_BIRD;
      end else if (in_pipe_r) begin
         colour_s = COL_PIPE;
      end else if (in_ground_r) begin
         colour_s = COL_GROUND;
      end else if ((state_r == ST_FLASH) && cnt_r[P_FLASH_PERIOD_LOG2]) begin
         colour_s = COL_FLASH;
      end else begin
         colour_s = COL_SKY;
      end
   end

   // Stage 2 output register and frame tick
   always_ff @(posedge clk) begin
      if (!reset) begin
         colour_r     <= COL_BLACK;
         frame_tick_r <= 1'b0;
      end else begin
         colour_r     <= colour_s;
         frame_tick_r <= latch_s;
      end
   end

   assign out_red    = colour_r[7:5];
   assign out_green  = colour_r[4:2];
   assign out_blue   = colour_r[1:0];
   assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_pitch_renderer.sv
// tb_pitch_renderer: drives pitch_renderer with directed and random hc/vc
// sequences (not a real raster, so many frames fit in few cycles) and compares
// every cycle against a frame-level reference model.
module tb_pitch_renderer;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] hc, vc, bird_y, pipe_x, pipe_y_top, pipe_y_bot;
   logic       collided;
   logic [2:0] out_red, out_green;
   logic [1:0] out_blue;
   logic       frame_tick;
   logic [7:0] dut_col;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pitch_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .hc         (hc),
      .vc         (vc),
      .bird_y     (bird_y),
      .pipe_x     (pipe_x),
      .pipe_y_top (pipe_y_top),
      .pipe_y_bot (pipe_y_bot),
      .collided   (collided),
      .out_red    (out_red),
      .out_green  (out_green),
      .out_blue   (out_blue),
      .frame_tick (frame_tick)
   );

   assign dut_col = {out_red, out_green, out_blue};

   // Reference model: frame snapshot, pending collision, flash frames left
   int         m_by = 0, m_px = 0, m_pt = 0, m_pb = 0;
   bit         m_sticky = 1'b0, m_flash = 1'b0;
   int         m_cnt = 0;
   logic [7:0] m_p1 = 8'h00, m_out = 8'h00;
   logic       m_tick = 1'b0;
   bit         started = 1'b0;

   function automatic logic [7:0] ref_colour(input int h, input int v, input int by,
                                             input int px, input int pt, input int pb,
                                             input bit fl, input int cnt);
      int x, y;
      x = h - 144;
      y = v - 35;
      if (!(x >= 0 && x < 640 && y >= 0 && y < 480)) return 8'h00;
      if (x >= 100 && x < 116 && y >= by && y < by + 16) return 8'hFC;
      if (x >= px && x < px + 48 && (y < pt || y >= pb)) return 8'h14;
      if (y >= 448) return 8'h88;
      if (fl && (((cnt / 8) % 2) == 1)) return 8'hE0;
      return 8'h57;
   endfunction

   always @(posedge clk) begin
      started <= 1'b1;
      if (!reset) begin
         m_by <= 0; m_px <= 0; m_pt <= 0; m_pb <= 0;
         m_sticky <= 1'b0; m_flash <= 1'b0; m_cnt <= 0;
         m_p1 <= 8'h00; m_out <= 8'h00; m_tick <= 1'b0;
      end else begin
         m_out  <= m_p1;
         m_p1   <= ref_colour(int'(hc), int'(vc), m_by, m_px, m_pt, m_pb, m_flash, m_cnt);
         m_tick <= (hc == 10'd0 && vc == 10'd515);
         if (hc == 10'd0 && vc == 10'd515) begin
            m_by <= int'(bird_y); m_px <= int'(pipe_x);
            m_pt <= int'(pipe_y_top); m_pb <= int'(pipe_y_bot);
            m_sticky <= 1'b0;
            if (m_sticky || collided) begin
               m_flash <= 1'b1;
               m_cnt   <= 59;
            end else if (m_flash) begin
               if (m_cnt == 0) m_flash <= 1'b0;
               else            m_cnt <= m_cnt - 1;
            end
         end else if (collided) begin
            m_sticky <= 1'b1;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         checks++;
         if (dut_col !== m_out) begin
            errors++;
            $display("FAIL colour t=%0t: got %h expected %h", $time, dut_col, m_out);
         end
         checks++;
         if (frame_tick !== m_tick) begin
            errors++;
            $display("FAIL frame_tick t=%0t: got %b expected %b", $time, frame_tick, m_tick);
         end
      end
   end

   task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int h, input int v, input bit col);
      @(negedge clk);
      hc = 10'(h);
      vc = 10'(v);
      collided = col;
   endtask

   // One pixel, then wait for it to emerge from the two-stage pipeline
   task automatic check_pix(input string name, input int x, input int y, input logic [7:0] exp);
      drive(144 + x, 35 + y, 1'b0);
      drive(0, 0, 1'b0);
      @(negedge clk);
      lit(name, dut_col, exp);
      lit({name, "_model"}, m_out, exp);
   endtask

   task automatic do_latch(input bit col);
      drive(0, 515, col);
      drive(0, 0, 1'b0);
      lit("tick_high", {7'd0, frame_tick}, 8'd1);
   endtask

   initial begin
      reset = 1'b0;
      hc = 10'd194; vc = 10'd85;
      bird_y = 10'd0; pipe_x = 10'd0; pipe_y_top = 10'd0; pipe_y_bot = 10'd0;
      collided = 1'b0;
      repeat (3) @(negedge clk);
      lit("reset_colour", dut_col, 8'h00);
      lit("reset_tick", {7'd0, frame_tick}, 8'd0);

      // Release with a visible pixel first; shadow pipe_x=0 covers x<48
      reset = 1'b1;
      hc = 10'd164; vc = 10'd135;
      drive(0, 0, 1'b0);
      @(negedge clk);
      lit("first_valid_pipe0", dut_col, 8'h14);
      check_pix("shadow0_sky", 300, 100, 8'h57);

      bird_y = 10'd200; pipe_x = 10'd620; pipe_y_top = 10'd100; pipe_y_bot = 10'd300;
      do_latch(1'b0);
      check_pix("bird", 100, 200, 8'hFC);
      check_pix("bird_right_edge", 116, 200, 8'h57);
      check_pix("pipe_639_50", 639, 50, 8'h14);
      check_pix("pipe_620_350", 620, 350, 8'h14);
      check_pix("pipe_gap", 630, 200, 8'h57);
      check_pix("no_wrap", 5, 50, 8'h57);
      check_pix("ground", 300, 460, 8'h88);
      check_pix("hblank", -134, 100, 8'h00);

      // Mid-frame change must not tear
      bird_y = 10'd300;
      check_pix("old_bird", 100, 200, 8'hFC);
      check_pix("new_bird_early", 100, 300, 8'h57);
      do_latch(1'b0);
      @(negedge clk);
      lit("tick_once", {7'd0, frame_tick}, 8'd0);
      check_pix("new_bird", 100, 300, 8'hFC);
      check_pix("old_bird_gone", 100, 200, 8'h57);

      // Collision pulse, then flash (cnt 59 has bit3 set)
      drive(144, 100, 1'b1);
      drive(0, 0, 1'b0);
      do_latch(1'b0);
      check_pix("flash_red", 300, 10, 8'hE0);
      repeat (19) do_latch(1'b0);
      drive(150, 200, 1'b1);
      do_latch(1'b0);                       // reload to 59
      repeat (44) do_latch(1'b0);           // cnt 15
      check_pix("reload_red", 300, 10, 8'hE0);
      repeat (8) do_latch(1'b0);            // cnt 7
      check_pix("cnt7_sky", 300, 10, 8'h57);
      repeat (8) do_latch(1'b0);            // 60 latches after reload: RUN
      check_pix("run_again", 300, 10, 8'h57);
      do_latch(1'b1);                       // collided on the latch cycle itself
      check_pix("latch_coll_red", 300, 10, 8'hE0);

      // Random frames
      for (int f = 0; f < 160; f++) begin
         if ($urandom_range(0, 3) == 0) bird_y = 10'($urandom_range(0, 490));
         if ($urandom_range(0, 3) == 0) pipe_x = 10'($urandom_range(0, 700));
         if ($urandom_range(0, 3) == 0) pipe_y_top = 10'($urandom_range(0, 480));
         if ($urandom_range(0, 3) == 0) pipe_y_bot = 10'($urandom_range(0, 480));
         for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 999) != 0);
            if ($urandom_range(0, 1) == 0) begin
               hc = 10'($urandom_range(0, 799));
               vc = 10'($urandom_range(0, 524));
            end else begin
               hc = 10'(144 + $urandom_range(80, 639));
               vc = 10'(35 + $urandom_range(0, 479));
            end
            collided = ($urandom_range(0, 399) == 0);
         end
         @(negedge clk);
         reset = 1'b1;
         hc = 10'd0; vc = 10'd515;
         collided = ($urandom_range(0, 15) == 0);
      end
      drive(0, 0, 1'b0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
